// File: rtl/ifft_in_buffer_if.sv
// ifft_in_buffer_if: sample stream in, frame handshake out.
// master = upstream/downstream side, slave = the buffer.
interface ifft_in_buffer_if #(
  parameter int DATA_W = 32
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     in_last;
  logic                     frame_valid;
  logic                     frame_ready;
  logic                     err_misalign;

  modport master (
    output in_valid,
    output in_re,
    output in_im,
    output in_last,
    output frame_ready,
    input  in_ready,
    input  frame_valid,
    input  err_misalign
  );

  modport slave (
    input  in_valid,
    input  in_re,
    input  in_im,
    input  in_last,
    input  frame_ready,
    output in_ready,
    output frame_valid,
    output err_misalign
  );
endinterface

// File: rtl/ifft_in_buffer.sv
// ifft_in_buffer: gathers 8 complex Q16.16 samples into a frame for an
// 8-point IFFT. Ports: clk, rst_n (async, active-low), bus (in_valid/
// in_ready/in_re/in_im/in_last, frame_valid/frame_ready, err_misalign),
// outr_0..outr_7 / outi_0..outi_7 (held frame, natural order).
// Build option: IFFT_IN_BUFFER_PINGPONG_EN selects two-bank buffering;
// without it a single bank alternates between FILL and HOLD.
module ifft_in_buffer #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ifft_in_buffer_if.slave          bus,
  output logic signed [DATA_W-1:0] outr_0,
  output logic signed [DATA_W-1:0] outr_1,
  output logic signed [DATA_W-1:0] outr_2,
  output logic signed [DATA_W-1:0] outr_3,
  output logic signed [DATA_W-1:0] outr_4,
  output logic signed [DATA_W-1:0] outr_5,
  output logic signed [DATA_W-1:0] outr_6,
  output logic signed [DATA_W-1:0] outr_7,
  output logic signed [DATA_W-1:0] outi_0,
  output logic signed [DATA_W-1:0] outi_1,
  output logic signed [DATA_W-1:0] outi_2,
  output logic signed [DATA_W-1:0] outi_3,
  output logic signed [DATA_W-1:0] outi_4,
  output logic signed [DATA_W-1:0] outi_5,
  output logic signed [DATA_W-1:0] outi_6,
  output logic signed [DATA_W-1:0] outi_7
);

`ifdef IFFT_IN_BUFFER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef logic signed [DATA_W-1:0] smp_t;

  smp_t       mem_re [NB][8];
  smp_t       mem_im [NB][8];
  logic [2:0] wr_idx;
  logic       in_ready_q;
  logic       fv_q;
  logic       err_q;
  logic       in_ready_n;
  logic       fv_n;
  logic       accept;
  logic       at_end;
  logic       close;
  logic       misalign;
  logic       retire;
  logic       wr_bank;
  logic       rd_bank;

  assign accept   = bus.in_valid & in_ready_q;
  assign at_end   = (wr_idx == 3'd7);
  // slot 7 always closes; in_last only matters before it
  assign close    = accept & at_end;
  assign misalign = accept & bus.in_last & ~at_end;
  assign retire   = fv_q & bus.frame_ready;

`ifdef IFFT_IN_BUFFER_PINGPONG_EN
  logic [1:0] full;
  logic [1:0] full_n;
  logic       wr_bank_n;
  logic       rd_bank_n;

  // close and retire never hit the same bank: close needs a
  // non-full write bank, retire needs a full read bank
  always_comb begin
    full_n    = full;
    wr_bank_n = wr_bank;
    rd_bank_n = rd_bank;
    if (retire) begin
      full_n[rd_bank] = 1'b0;
      rd_bank_n       = ~rd_bank;
    end
    if (close) begin
      full_n[wr_bank] = 1'b1;
      wr_bank_n       = ~wr_bank;
    end
    in_ready_n = ~full_n[wr_bank_n];
    fv_n       = full_n[rd_bank_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full    <= full_n;
      wr_bank <= wr_bank_n;
      rd_bank <= rd_bank_n;
    end
  end
`else
  typedef enum logic {FILL, HOLD} state_t;

  state_t state;
  state_t state_n;

  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FILL:    if (close)  state_n = HOLD;
      HOLD:    if (retire) state_n = FILL;
      default: state_n = FILL;
    endcase
    in_ready_n = (state_n == FILL);
    fv_n       = (state_n == HOLD);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx     <= 3'd0;
      in_ready_q <= 1'b0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < 8; k++) begin
          mem_re[b][k] <= '0;
          mem_im[b][k] <= '0;
        end
      end
    end else begin
      in_ready_q <= in_ready_n;
      fv_q       <= fv_n;
      err_q      <= misalign;
      if (misalign) begin
        wr_idx <= 3'd0;
      end else if (accept) begin
        mem_re[wr_bank][wr_idx] <= bus.in_re;
        mem_im[wr_bank][wr_idx] <= bus.in_im;
        wr_idx                  <= wr_idx + 3'd1;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.frame_valid  = fv_q;
  assign bus.err_misalign = err_q;

  assign outr_0 = mem_re[rd_bank][0];
  assign outr_1 = mem_re[rd_bank][1];
  assign outr_2 = mem_re[rd_bank][2];
  assign outr_3 = mem_re[rd_bank][3];
  assign outr_4 = mem_re[rd_bank][4];
  assign outr_5 = mem_re[rd_bank][5];
  assign outr_6 = mem_re[rd_bank][6];
  assign outr_7 = mem_re[rd_bank][7];
  assign outi_0 = mem_im[rd_bank][0];
  assign outi_1 = mem_im[rd_bank][1];
  assign outi_2 = mem_im[rd_bank][2];
  assign outi_3 = mem_im[rd_bank][3];
  assign outi_4 = mem_im[rd_bank][4];
  assign outi_5 = mem_im[rd_bank][5];
  assign outi_6 = mem_im[rd_bank][6];
  assign outi_7 = mem_im[rd_bank][7];

endmodule

// File: tb/tb_ifft_in_buffer.sv
// tb_ifft_in_buffer: directed test of ifft_in_buffer.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ifft_in_buffer;

`ifdef IFFT_IN_BUFFER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ifft_in_buffer_if #(.DATA_W(32)) bus ();

  logic signed [31:0] outr_0, outr_1, outr_2, outr_3;
  logic signed [31:0] outr_4, outr_5, outr_6, outr_7;
  logic signed [31:0] outi_0, outi_1, outi_2, outi_3;
  logic signed [31:0] outi_4, outi_5, outi_6, outi_7;

  ifft_in_buffer #(.DATA_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .outr_0 (outr_0),
    .outr_1 (outr_1),
    .outr_2 (outr_2),
    .outr_3 (outr_3),
    .outr_4 (outr_4),
    .outr_5 (outr_5),
    .outr_6 (outr_6),
    .outr_7 (outr_7),
    .outi_0 (outi_0),
    .outi_1 (outi_1),
    .outi_2 (outi_2),
    .outi_3 (outi_3),
    .outi_4 (outi_4),
    .outi_5 (outi_5),
    .outi_6 (outi_6),
    .outi_7 (outi_7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called on a falling edge; returns on the falling edge after accept
  task automatic send(input logic [31:0] re,
                      input logic [31:0] im,
                      input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_im    = im;
    bus.in_last  = last;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic retire_pulse();
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_re       = '0;
    bus.in_im       = '0;
    bus.in_last     = 1'b0;
    bus.frame_ready = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_err", 32'(bus.err_misalign), 32'd0);
    chk("rst_outr0", outr_0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    // ramp frame
    for (int k = 0; k < 8; k++)
      send(32'(k * 32'h10000), 32'(-(k * 32'h10000)), k == 7);
    chk("f1_fv", 32'(bus.frame_valid), 32'd1);
    chk("f1_outr3", outr_3, 32'h0003_0000);
    chk("f1_outi3", outi_3, 32'hFFFD_0000);
    chk("f1_outr7", outr_7, 32'h0007_0000);
    chk("f1_outi0", outi_0, 32'h0000_0000);
    chk("f1_in_ready", 32'(bus.in_ready), 32'(PP));

    // hold 20 cycles, then one retire
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold_fv", 32'(bus.frame_valid), 32'd1);
      chk("hold_outr3", outr_3, 32'h0003_0000);
      chk("hold_outi7", outi_7, 32'hFFF9_0000);
    end
    retire_pulse();
    chk("ret_fv", 32'(bus.frame_valid), 32'd0);
    chk("ret_in_ready", 32'(bus.in_ready), 32'd1);

    // frame_ready with no frame held
    retire_pulse();
    chk("idle_ret_fv", 32'(bus.frame_valid), 32'd0);

    // misaligned in_last at slot 3
    for (int k = 0; k < 3; k++)
      send(32'h0000_00A0 + 32'(k), 32'd0, 1'b0);
    send(32'h0000_00A3, 32'd0, 1'b1);
    chk("mis_err", 32'(bus.err_misalign), 32'd1);
    chk("mis_fv", 32'(bus.frame_valid), 32'd0);
    @(negedge clk);
    chk("mis_err_clr", 32'(bus.err_misalign), 32'd0);
    for (int k = 0; k < 8; k++)
      send(32'h100 + 32'(k), 32'h200 + 32'(k), k == 7);
    chk("mis_fv2", 32'(bus.frame_valid), 32'd1);
    chk("mis_outr0", outr_0, 32'h0000_0100);
    chk("mis_outr7", outr_7, 32'h0000_0107);
    chk("mis_outi2", outi_2, 32'h0000_0202);
    chk("mis_err_done", 32'(bus.err_misalign), 32'd0);
    retire_pulse();
    chk("mis_ret_fv", 32'(bus.frame_valid), 32'd0);

    // reset mid-fill
    for (int k = 0; k < 5; k++)
      send(32'h0000_0777, 32'h0000_0888, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("mid_rst_outr0", outr_0, 32'd0);
    chk("mid_rst_outi4", outi_4, 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rel_fv", 32'(bus.frame_valid), 32'd0);
    for (int k = 0; k < 8; k++)
      send(32'h50 + 32'(k), 32'h60 + 32'(k), k == 7);
    chk("clean_fv", 32'(bus.frame_valid), 32'd1);
    chk("clean_outr0", outr_0, 32'h0000_0050);
    chk("clean_outr4", outr_4, 32'h0000_0054);
    chk("clean_outi7", outi_7, 32'h0000_0067);
    retire_pulse();

    // slot 7 closes even without in_last
    for (int k = 0; k < 8; k++)
      send(32'h900 + 32'(k), 32'h0, 1'b0);
    chk("nolast_fv", 32'(bus.frame_valid), 32'd1);
    chk("nolast_outr6", outr_6, 32'h0000_0906);
    chk("nolast_err", 32'(bus.err_misalign), 32'd0);
    retire_pulse();
    chk("nolast_ret", 32'(bus.frame_valid), 32'd0);

`ifdef IFFT_IN_BUFFER_PINGPONG_EN
    // two frames back to back, no consumer
    for (int k = 0; k < 16; k++) begin
      chk("pp_ready", 32'(bus.in_ready), 32'd1);
      send(32'h1000 * 32'(k / 8 + 1) + 32'(k % 8), 32'h0, (k % 8) == 7);
    end
    @(negedge clk);
    chk("pp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("pp_fv1", 32'(bus.frame_valid), 32'd1);
    chk("pp_f1_outr0", outr_0, 32'h0000_1000);
    retire_pulse();
    chk("pp_fv2", 32'(bus.frame_valid), 32'd1);
    chk("pp_f2_outr0", outr_0, 32'h0000_2000);
    chk("pp_f2_outr5", outr_5, 32'h0000_2005);
    chk("pp_ready_back", 32'(bus.in_ready), 32'd1);
    retire_pulse();
    chk("pp_empty", 32'(bus.frame_valid), 32'd0);

    // streaming with consumer always ready
    bus.frame_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      chk("st_ready", 32'(bus.in_ready), 32'd1);
      send(32'h4000 * 32'(k / 8 + 1) + 32'(k % 8), 32'h0, (k % 8) == 7);
      if ((k % 8) == 7) begin
        chk("st_fv", 32'(bus.frame_valid), 32'd1);
        chk("st_outr0", outr_0, 32'h4000 * 32'(k / 8 + 1));
      end
    end
    @(negedge clk);
    bus.frame_ready = 1'b0;
    chk("st_done_fv", 32'(bus.frame_valid), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
